// File: rtl/block_probe.sv
// Read-side probe of a 4x4 block footprint: scans 16 pixels (x fastest) and flags non-background ones.
// Latency: done is high 16 + RD_LATENCY cycles after the start-accept edge; start is honoured only in IDLE.
module block_probe #(
  parameter int         SCREEN_W   = 160,
  parameter int         SCREEN_H   = 120,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter int         RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] occ_mask,
  output logic [4:0]  occ_count,
  output logic        occupied
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       issued;
    logic [3:0] idx;
  } pipe_t;

  localparam logic [8:0] SCR_W9 = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8 = 8'(SCREEN_H);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [1:0]  dcnt_q;
  logic        rd_en_q;
  logic [14:0] rd_addr_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] occ_mask_q;
  logic [4:0]  occ_count_q;
  logic        occupied_q;
  pipe_t       pipe_q [RD_LATENCY];

  logic [3:0]  nidx;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic [15:0] nxt;
  pipe_t       tail;
  pipe_t       push;
  logic        hit;
  logic [15:0] occ_mask_d;
  logic [4:0]  occ_count_d;

  // Returns {on_screen, address}; off-screen pixels get address 0 so rd_addr never leaves 15 bits.
  function automatic logic [15:0] probe_addr(input logic [3:0] idx, input logic [7:0] ox,
                                             input logic [6:0] oy);
    logic [8:0]  px;
    logic [7:0]  py;
    logic [14:0] lin;
    px  = {1'b0, ox} + {7'd0, idx[1:0]};
    py  = {1'b0, oy} + {6'd0, idx[3:2]};
    lin = 15'(py) * 15'(SCREEN_W) + 15'(px);
    if ((px < SCR_W9) && (py < SCR_H8)) begin
      probe_addr = {1'b1, lin};
    end else begin
      probe_addr = 16'd0;
    end
  endfunction

  // The address for the pixel issued next cycle is prepared here so rd_en/rd_addr come straight from flops.
  always_comb begin
    bx   = x_q;
    by   = y_q;
    nidx = idx_q + 4'd1;
    if (state_q == IDLE) begin
      bx   = x;
      by   = y;
      nidx = 4'd0;
    end
    nxt = probe_addr(nidx, bx, by);
  end

  always_comb begin
    tail        = pipe_q[RD_LATENCY-1];
    push        = '{issued: rd_en_q, idx: idx_q};
    hit         = tail.issued && (rd_data != BG_COLOUR);
    occ_mask_d  = occ_mask_q | (16'd1 << tail.idx);
    occ_count_d = occ_count_q + 5'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      dcnt_q      <= 2'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 15'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      occ_mask_q  <= 16'd0;
      occ_count_q <= 5'd0;
      occupied_q  <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      done_q <= 1'b0;
      if (hit) begin
        occ_mask_q  <= occ_mask_d;
        occ_count_q <= occ_count_d;
        occupied_q  <= |occ_mask_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SCAN;
            x_q         <= x;
            y_q         <= y;
            idx_q       <= 4'd0;
            busy_q      <= 1'b1;
            occ_mask_q  <= 16'd0;
            occ_count_q <= 5'd0;
            occupied_q  <= 1'b0;
            rd_en_q     <= nxt[15];
            rd_addr_q   <= nxt[14:0];
          end
        end
        SCAN: begin
          if (idx_q == 4'd15) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            dcnt_q  <= 2'(RD_LATENCY - 1);
          end else begin
            idx_q     <= idx_q + 4'd1;
            rd_en_q   <= nxt[15];
            rd_addr_q <= nxt[14:0];
          end
        end
        DRAIN: begin
          // The last read's data is at the pipeline tail on the final drain cycle.
          if (dcnt_q == 2'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q - 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign occ_mask  = occ_mask_q;
  assign occ_count = occ_count_q;
  assign occupied  = occupied_q;

endmodule

// File: tb/tb_block_probe.sv
// Bench for block_probe: two instances (RD_LATENCY 1 and 3) against a framebuffer model and a per-probe reference.
module tb_block_probe;
  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start1, start3;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        rd_en1, rd_en3;
  logic [14:0] addr1, addr3;
  logic [2:0]  data1, data3;
  logic        busy1, busy3, done1, done3, occ1, occ3;
  logic [15:0] mask1, mask3;
  logic [4:0]  cnt1, cnt3;

  always #5 clk = ~clk;

  block_probe #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .x(x), .y(y),
    .rd_en(rd_en1), .rd_addr(addr1), .rd_data(data1),
    .busy(busy1), .done(done1), .occ_mask(mask1), .occ_count(cnt1), .occupied(occ1)
  );

  block_probe #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .x(x), .y(y),
    .rd_en(rd_en3), .rd_addr(addr3), .rd_data(data3),
    .busy(busy3), .done(done3), .occ_mask(mask3), .occ_count(cnt3), .occupied(occ3)
  );

  // Framebuffer with 1- and 3-cycle read pipes; idle read slots return a non-background colour.
  logic [2:0] fb [W*H];
  logic [2:0] p3a, p3b;
  always @(posedge clk) begin
    data1 <= rd_en1 ? fb[addr1] : 3'b111;
    p3a   <= rd_en3 ? fb[addr3] : 3'b111;
    p3b   <= p3a;
    data3 <= p3b;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_q [$];
  logic [15:0] exp_mask;
  int          exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic obs(input int sel, output logic e, output logic [14:0] a, output logic b,
                     output logic d, output logic [15:0] m, output logic [4:0] c, output logic o);
    if (sel == 3) begin
      e = rd_en3; a = addr3; b = busy3; d = done3; m = mask3; c = cnt3; o = occ3;
    end else begin
      e = rd_en1; a = addr1; b = busy1; d = done1; m = mask1; c = cnt1; o = occ1;
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 3) start3 = v;
    else start1 = v;
  endtask

  // Reference: walk the 16 footprint pixels in plot order, keep on-screen ones.
  task automatic build_model(input int bx, input int by);
    exp_q.delete();
    exp_mask = 16'd0;
    exp_cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      int px = bx + i % 4;
      int py = by + i / 4;
      if (px < W && py < H) begin
        exp_q.push_back(py * W + px);
        if (fb[py * W + px] != 3'b000) begin
          exp_mask[i] = 1'b1;
          exp_cnt++;
        end
      end
    end
  endtask

  // Entered on the negedge just after the accept edge; returns on the negedge where done is seen.
  task automatic scan(input int sel, input bit wiggle);
    int lat = (sel == 3) ? 3 : 1;
    int n = 0;
    bit seen = 0;
    logic e, b, d, o;
    logic [14:0] a;
    logic [15:0] m;
    logic [4:0] c;
    obs(sel, e, a, b, d, m, c, o);
    check("accept_busy", b, 1);
    while (n < 64) begin
      obs(sel, e, a, b, d, m, c, o);
      if (e) begin
        if (exp_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", a, exp_q.pop_front());
      end
      if (d) begin
        seen = 1;
        break;
      end
      if (wiggle) begin
        x = 8'($urandom);
        y = 7'($urandom);
      end
      n++;
      @(negedge clk);
    end
    check("done_seen", seen, 1);
    // n counts edges after the accept edge: done in cycle 17+lat counting the accept cycle as 1.
    check("done_lat", n, 16 + lat);
    check("reads_left", exp_q.size(), 0);
    check("busy_at_done", b, 0);
    check("occ_mask", m, exp_mask);
    check("occ_count", c, exp_cnt);
    check("occupied", o, exp_mask != 16'd0);
  endtask

  task automatic probe(input int sel, input int bx, input int by, input bit wiggle);
    logic e, b, d, o;
    logic [14:0] a;
    logic [15:0] m;
    logic [4:0] c;
    build_model(bx, by);
    @(negedge clk);
    x = 8'(bx);
    y = 7'(by);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    scan(sel, wiggle);
    @(negedge clk);
    obs(sel, e, a, b, d, m, c, o);
    check("done_pulse", d, 0);
    check("idle_busy", b, 0);
    check("idle_mask_hold", m, exp_mask);
  endtask

  task automatic check_reset_outputs(input int sel, input string tag);
    logic e, b, d, o;
    logic [14:0] a;
    logic [15:0] m;
    logic [4:0] c;
    obs(sel, e, a, b, d, m, c, o);
    check({tag, "_rd_en"}, e, 0);
    check({tag, "_rd_addr"}, a, 0);
    check({tag, "_busy"}, b, 0);
    check({tag, "_done"}, d, 0);
    check({tag, "_mask"}, m, 0);
    check({tag, "_count"}, c, 0);
    check({tag, "_occ"}, o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic e, b, d, o;
    logic [14:0] a;
    logic [15:0] m;
    logic [4:0] c;
    int dones;
    resetn = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    x = 8'd0;
    y = 7'd0;
    for (int i = 0; i < W * H; i++) fb[i] = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1, "rst1");
    check_reset_outputs(3, "rst3");
    resetn = 1'b1;

    // All background: addresses 3210.., empty result.
    probe(1, 10, 20, 0);

    // Two coloured pixels inside the (10,20) footprint.
    fb[21 * W + 12] = 3'b100;
    fb[23 * W + 13] = 3'b100;
    probe(1, 10, 20, 0);
    check("two_px_mask_const", mask1, 16'h8040);
    check("two_px_cnt_const", cnt1, 2);

    // Corner clip, one on-screen coloured pixel; off-screen slots see noise data.
    fb[119 * W + 159] = 3'b010;
    probe(1, 158, 118, 0);
    probe(3, 158, 118, 0);
    check("clip_mask_const", mask3, 16'h0020);

    // Held start with mid-scan x/y wiggle: back-to-back probes with one idle gap.
    build_model(10, 20);
    @(negedge clk);
    x = 8'd10;
    y = 7'd20;
    start1 = 1'b1;
    @(negedge clk);
    scan(1, 1);
    @(negedge clk);
    obs(1, e, a, b, d, m, c, o);
    check("hold_gap_done", d, 0);
    check("hold_gap_busy", b, 0);
    x = 8'd157;
    y = 7'd117;
    build_model(157, 117);
    @(negedge clk);
    scan(1, 1);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    obs(1, e, a, b, d, m, c, o);
    check("hold_release_busy", b, 0);

    // Reset at scan pixel 7 with early pixels occupied.
    for (int i = 0; i < 8; i++) fb[(60 + i / 4) * W + 70 + i % 4] = 3'b011;
    build_model(70, 60);
    @(negedge clk);
    x = 8'd70;
    y = 7'd60;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs(1, "midrst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_busy", busy1, 0);
    probe(1, 70, 60, 0);

    // Fully coloured block on the 3-cycle instance.
    for (int i = 0; i < 16; i++) fb[(50 + i / 4) * W + 40 + i % 4] = 3'(1 + $urandom_range(0, 6));
    probe(3, 40, 50, 0);
    check("full_mask_const", mask3, 16'hFFFF);
    check("full_cnt_const", cnt3, 16);

    // Random framebuffer and probes, including off-screen origins.
    for (int i = 0; i < W * H; i++) fb[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    for (int k = 0; k < 14; k++) begin
      probe(($urandom_range(0, 1) == 1) ? 3 : 1, int'($urandom_range(0, 165)),
            int'($urandom_range(0, 123)), 1);
      check("rand_popcount", (k % 2 == 0) ? $countones(mask1) : $countones(mask3),
            (k % 2 == 0) ? cnt1 : cnt3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
